data_mem_responder: RTL and testbench

- Memory-side responder for the CPU MEM-stage data-access interface.
- Accepts one read or write request at a time over a valid/ready request channel.
- Models a fixed, parameterised access latency against an internal word-addressed store.
- Returns read data, or a write acknowledge, over a valid/ready response channel, so the pipeline can stall on memory instead of assuming single-cycle access.

---
 rtl/data_mem_responder.sv | 146 ++++++++++++++
 tb/tb_data_mem_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: valid/ready data-memory responder with a fixed access latency.
// Define DATA_MEM_RESPONDER_STATS_EN to add saturating read/write/error counters.
module data_mem_responder #(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LATENCY = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WRITE,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR
`ifdef DATA_MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0] STAT_READS,
    output logic [31:0] STAT_WRITES,
    output logic [31:0] STAT_ERRORS
`endif
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            out_of_reset;
    logic            accept;
    logic            access;
    logic            done;
    logic            addr_err;

    logic [3:0]      cnt;
    logic            wr_q;
    logic            err_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;

    logic [31:0]     mem [DEPTH];

    // Misaligned or beyond the store: upper address bits must all be zero, no aliasing.
    assign addr_err  = (REQ_ADDR[1:0] != 2'b00) || (REQ_ADDR[31:AW+2] != '0);

    assign REQ_READY = out_of_reset && (state == IDLE);
    assign RSP_VALID = (state == RESP);

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state        <= IDLE;
            out_of_reset <= 1'b0;
        end else begin
            state        <= state_next;
            out_of_reset <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        access     = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (REQ_VALID && REQ_READY) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    access     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            cnt       <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            RSP_RDATA <= '0;
            RSP_ERR   <= 1'b0;
        end else begin
            if (accept) begin
                cnt     <= LAT_LOAD;
                wr_q    <= REQ_WRITE;
                err_q   <= addr_err;
                idx_q   <= REQ_ADDR[AW+1:2];
                wdata_q <= REQ_WDATA;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                RSP_ERR   <= err_q;
                RSP_RDATA <= (err_q || wr_q) ? '0 : mem[idx_q];
            end
        end
    end

    // Store is not reset; the write fires only on the access edge of a clean write.
    always_ff @(posedge CLOCK) begin
        if (access && wr_q && !err_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

`ifdef DATA_MEM_RESPONDER_STATS_EN
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            STAT_READS  <= '0;
            STAT_WRITES <= '0;
            STAT_ERRORS <= '0;
        end else if (done) begin
            if (err_q) begin
                if (STAT_ERRORS != '1) STAT_ERRORS <= STAT_ERRORS + 32'd1;
            end else if (wr_q) begin
                if (STAT_WRITES != '1) STAT_WRITES <= STAT_WRITES + 32'd1;
            end else begin
                if (STAT_READS != '1) STAT_READS <= STAT_READS + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks of data_mem_responder
// against an array-based memory model with an in-order expectation queue.
module tb_data_mem_responder;

    localparam int unsigned DEPTH   = 512;
    localparam int unsigned LATENCY = 2;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef DATA_MEM_RESPONDER_STATS_EN
    logic [31:0] stat_reads;
    logic [31:0] stat_writes;
    logic [31:0] stat_errors;
`endif

    data_mem_responder #(
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY)
    ) dut (
        .CLOCK    (clk),
        .RESET    (rst_n),
        .REQ_VALID(req_valid),
        .REQ_READY(req_ready),
        .REQ_WRITE(req_write),
        .REQ_ADDR (req_addr),
        .REQ_WDATA(req_wdata),
        .RSP_VALID(rsp_valid),
        .RSP_READY(rsp_ready),
        .RSP_RDATA(rsp_rdata),
        .RSP_ERR  (rsp_err)
`ifdef DATA_MEM_RESPONDER_STATS_EN
        ,
        .STAT_READS (stat_reads),
        .STAT_WRITES(stat_writes),
        .STAT_ERRORS(stat_errors)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        wr;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model [DEPTH];
    exp_t        pend [$];
    int          m_reads = 0;
    int          m_writes = 0;
    int          m_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one request and return at the negedge after the accepting edge.
    task automatic present(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.wr  = wr;
        e.err = (addr % 4 != 0) || (addr / 4 >= DEPTH);
        e.rd  = (e.err || wr) ? 32'd0 : model[addr / 4];
        if (!e.err && wr) model[addr / 4] = wdata;
        pend.push_back(e);
        present(wr, addr, wdata);
    endtask

    task automatic finish(input int stall);
        exp_t e;
        int   lat = 0;
        e = pend.pop_front();
        check("wait_req_ready", 32'(req_ready), 32'd0);
        rsp_ready = (stall == 0);
        while (!rsp_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(LATENCY));
        check("rdata", rsp_rdata, e.rd);
        check("err", 32'(rsp_err), 32'(e.err));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, e.rd);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        check("idle_req_ready", 32'(req_ready), 32'd1);
        if (e.err) m_errors++;
        else if (e.wr) m_writes++;
        else m_reads++;
        rsp_ready = 1'($urandom);
    endtask

    task automatic check_stats(input string tag);
`ifdef DATA_MEM_RESPONDER_STATS_EN
        check({tag, "_reads"}, stat_reads, 32'(m_reads));
        check({tag, "_writes"}, stat_writes, 32'(m_writes));
        check({tag, "_errors"}, stat_errors, 32'(m_errors));
`else
        check({tag, "_no_rsp"}, 32'(rsp_valid), 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] a;
        int          sel;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        check("rel_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check_stats("stats_rst0");

        for (int i = 0; i < int'(DEPTH); i++) begin
            send(1'b1, 32'(i * 4), $urandom);
            finish(0);
        end

        send(1'b1, 32'h10, 32'hDEADBEEF);
        finish(0);
        send(1'b0, 32'h10, 32'h0);
        finish(0);

        send(1'b0, 32'h6, 32'h0);
        finish(0);
        send(1'b1, 32'h800, 32'hA5A5A5A5);
        finish(0);
        send(1'b0, 32'h0, 32'h0);
        finish(0);

        send(1'b0, 32'h10, 32'h0);
        finish(5);

        // Second request held valid through WAIT/RESP of the first.
        send(1'b1, 32'h40, 32'h0BADF00D);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h40;
        req_wdata = 32'h0;
        finish(2);
        send(1'b0, 32'h40, 32'h0);
        finish(0);
        repeat (4) begin
            @(negedge clk);
            check("no_extra_rsp", 32'(rsp_valid), 32'd0);
        end
        check_stats("stats_mid");

        // Reset during WAIT drops the write.
        rsp_ready = 1'b1;
        present(1'b1, 32'h20, 32'h12345678);
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (LATENCY + 2) begin
            @(negedge clk);
            check("midrst_hold_valid", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        m_reads  = 0;
        m_writes = 0;
        m_errors = 0;
        @(negedge clk);
        check("midrst_ready_back", 32'(req_ready), 32'd1);
        check("midrst_valid_back", 32'(rsp_valid), 32'd0);
        check_stats("stats_rst1");
        send(1'b0, 32'h20, 32'h0);
        finish(0);

        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                a = $urandom;
                if (a[1:0] == 2'b00) a = a | 32'h1;
            end else if (sel == 1) begin
                a = (32'(DEPTH) * 4 + ($urandom_range(0, 4000) * 4)) | ($urandom & 32'hF000_0000);
            end else begin
                a = 32'($urandom_range(0, DEPTH - 1) * 4);
            end
            send(1'($urandom), a, $urandom);
            finish(int'($urandom_range(0, 3)));
        end
        check_stats("stats_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
